// File: rtl/serdes_pkg.sv
// Shared frame geometry, receiver state encoding and symbol layout for the serial link.
package serdes_pkg;

    localparam int FRAME_BITS = 27;
    localparam int SYM_BITS   = 9;
    localparam int NUM_SYMS   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STOP  = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic       k;
        logic [7:0] octet;
    } symbol_t;

    // Symbol idx of a frame; symbol0 sits in the low bits.
    function automatic symbol_t frame_sym(input logic [FRAME_BITS-1:0] f, input int idx);
        return symbol_t'(f[idx*SYM_BITS +: SYM_BITS]);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Frame buffer: power-of-two depth, head presented on a valid/ready stream.
// A push into a full buffer succeeds only when a pop frees a slot in the same cycle.
module sync_fifo
    import serdes_pkg::*;
#(
    parameter int WIDTH = FRAME_BITS,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_drop;

    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_full = (r_count == (AW+1)'(DEPTH));
    assign w_pop  = i_pop && (r_count != '0);
    assign w_wr   = i_push && (!w_full || w_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= i_push && w_full && !w_pop;
            if (w_wr) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_valid = (r_count != '0);
    assign o_drop  = r_drop;

endmodule

// File: rtl/serial_deserializer.sv
// Serial frame receiver: input synchronizer, start/27 data/stop framing FSM and frame FIFO.
// Build option SERDES_KCODE_CHECK_EN also rejects frames whose symbol2 k bit is 0.
module serial_deserializer
    import serdes_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  data_i,
    output logic [FRAME_BITS-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  frame_err_o,
    output logic                  drop_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    rx_state_t              r_state;
    logic [4:0]             r_cnt;
    logic [FRAME_BITS-1:0]  r_shift;
    logic                   r_frame_ok;
    logic                   r_frame_err;
    logic                   r_push;

    logic w_sd;
    logic w_stop_ok;

    assign w_sd = r_sync[SYNC_STAGES-1];

`ifdef SERDES_KCODE_CHECK_EN
    symbol_t w_sym2;
    assign w_sym2 = frame_sym(r_shift, NUM_SYMS-1);

    always_comb begin
        w_stop_ok = !w_sd && w_sym2.k;
    end
`else
    always_comb begin
        w_stop_ok = !w_sd;
    end
`endif

    // r_shift stays untouched through IDLE, so the push stage can write it directly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync      <= '0;
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_push      <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], data_i};
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_push      <= r_frame_ok;
            case (r_state)
                IDLE: begin
                    if (w_sd) begin
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_shift <= {r_shift[FRAME_BITS-2:0], w_sd};
                    r_cnt   <= r_cnt + 5'd1;
                    if (r_cnt == 5'(FRAME_BITS-1)) begin
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    r_frame_ok  <= w_stop_ok;
                    r_frame_err <= !w_stop_ok;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign frame_err_o = r_frame_err;

    sync_fifo #(
        .WIDTH(FRAME_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_push (r_push),
        .i_data (r_shift),
        .i_pop  (ready_i),
        .o_data (data_o),
        .o_valid(valid_o),
        .o_drop (drop_o)
    );

endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Receive-side counterpart to the Wishbone-fed serializer. Recovers 27-bit frames from a one-bit-per-clock serial line. Each frame holds three 9-bit symbols of the form {k, byte}, where k=1 marks a kcode. Complete frames are buffered in a small FIFO and presented on a valid/ready stream to the downstream consumer, such as a Wishbone read-back slave.

## Interface
Parameters:
- FIFO_DEPTH, 4: number of frames buffered. Must be a power of two, ≥2.
- SYNC_STAGES, 2: flops in the `data_i` input synchronizer, ≥2.

Ports:
- clk_i  in  1  clock. All logic is on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- data_i  in  1  serial line. Idles low.
- data_o  out  27  frame at FIFO head: [26:18] symbol2, [17:9] symbol1, [8:0] symbol0. Bit 8 of each symbol is k.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer accepts `data_o` when `valid_o && ready_i`.
- frame_err_o  out  1  one-cycle pulse when a frame is discarded for a bad stop bit, or for a kcode violation when the kcode check is compiled in.
- drop_o  out  1  one-cycle pulse when a good frame is lost because the FIFO is full.

## Operation
- Line format: start bit (1), then 27 data bits MSB first (bit 26 first), then stop bit (0). One bit per clk_i.
- All decoding uses the synchronized line `sd`, taken from the last synchronizer stage.
- FSM states: IDLE, SHIFT, STOP.
  - IDLE: on `sd`=1, clear the bit counter and go to SHIFT.
  - SHIFT: on each cycle, shift `sd` into a 27-bit shift register and increment the 5-bit counter. After the 27th bit, go to STOP.
  - STOP: if `sd`=0, the frame is good and is pushed. If `sd`=1, pulse `frame_err_o` and discard the frame. Always return to IDLE.
- Back-to-back frames: a start bit in the cycle immediately after STOP is accepted.
- Push:
  - A good frame is written the cycle after STOP.
  - If the FIFO is full and no pop occurs that same cycle, the frame is dropped and `drop_o` pulses.
  - Push while full with a simultaneous pop is accepted; occupancy is unchanged.
- Pop: on `valid_o && ready_i`. Pop and push in the same cycle are both performed.
- FIFO occupancy counter is clog2(FIFO_DEPTH)+1 bits wide. Read and write pointers wrap modulo FIFO_DEPTH.
- Reset values: `valid_o`=0, `data_o`=0, `frame_err_o`=0, `drop_o`=0. FSM in IDLE, FIFO empty, synchronizer flops cleared.
- Reset asserted mid-frame or mid-FIFO: all state is discarded immediately and no partial frame is ever output. After release, a line that is already high is treated as a start bit.

## Timing
- Start-bit detection: the start bit is first sampled on `data_i` at edge 0 and appears on `sd` after SYNC_STAGES edges.
- Latency: `valid_o` rises SYNC_STAGES+30 cycles after edge 0 when the FIFO was empty. This is 1 start + 27 data + 1 stop + 1 push cycle.
- `valid_o` and `data_o` are registered and change only on clock edges.
- `data_o` is held stable while `valid_o && !ready_i`.
- `frame_err_o` and `drop_o` are registered, each high for exactly one cycle per event.
- Sustained throughput: one frame per 29 cycles. With `ready_i` held high, the FIFO never fills.

## Configuration
- `SERDES_KCODE_CHECK_EN`:
  - Defined: a frame whose symbol2 k bit is 0 is discarded in STOP even if the stop bit is good. In that case `frame_err_o` pulses and nothing is pushed.
  - Undefined: k bits pass through unchecked and only the stop bit is validated.

## Structure
- Package `serdes_pkg`:
  - FRAME_BITS=27, SYM_BITS=9, NUM_SYMS=3.
  - Enum `rx_state_t` {IDLE, SHIFT, STOP}.
  - Typedef `symbol_t` as a packed struct {k, byte[7:0]}.
- Sub-module `sync_fifo`, parameterized by width and depth, holds the buffer. The FSM, shift register and synchronizer stay in `serial_deserializer`.

## Test plan
- Single frame: send frame 0x6F15455 (symbols 0x1BC, 0x0AA, 0x055) with `ready_i`=1.
  - `valid_o` rises SYNC_STAGES+30 cycles after the start bit, with `data_o`=0x6F15455.
  - `valid_o` is held 1 cycle, then drops; `frame_err_o`=0.
- Bad stop bit: send the same frame with stop bit=1. `frame_err_o` pulses once, `valid_o` stays 0, and the next good frame is received intact.
- Overflow: with `ready_i`=0, send 5 back-to-back good frames, values 1..5.
  - FIFO holds 1..4 and `drop_o` pulses once, for frame 5.
  - Then raise `ready_i`: outputs 1, 2, 3, 4 on consecutive cycles, then `valid_o`=0.
- Full push/pop collision: with the FIFO full, arrange for `ready_i`=1 in exactly the push cycle. No `drop_o`, occupancy stays 4, and output order is preserved.
- Reset mid-frame: assert `rst_i` after 10 data bits, then release.
  - All outputs are 0 immediately.
  - The remaining bits of the aborted frame must not produce `valid_o`.
  - A following good frame is received.
- Kcode check (`SERDES_KCODE_CHECK_EN` defined): send frame 0x0F15455 (symbol2 k=0). `frame_err_o` pulses and nothing is pushed. With the macro undefined, the same frame is output unchanged.
